// File: rtl/mmio_uart_tx_pkg.sv
// mmio_uart_tx_pkg -- shared constants for the memory-mapped UART transmitter.
// Register offsets, STATUS bit positions, FIFO depth and the TX state encoding.
// Build macro MMIO_UART_TX_FIFO_EN selects an 8-entry byte FIFO; without it the
// transmitter has a single holding register.
package mmio_uart_tx_pkg;

  // Register offsets relative to BASE_ADDR
  localparam logic [31:0] TXDATA_OFS = 32'h0;
  localparam logic [31:0] STATUS_OFS = 32'h4;

  // STATUS bit positions
  localparam int STAT_FULL_BIT = 0;
  localparam int STAT_BUSY_BIT = 1;
  localparam int STAT_OVF_BIT  = 2;

`ifdef MMIO_UART_TX_FIFO_EN
  localparam int FIFO_DEPTH = 8;
`else
  localparam int FIFO_DEPTH = 1;
`endif

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } tx_state_e;

  // Pack the STATUS register image
  function automatic logic [31:0] status_word(input logic ovf, input logic busy,
                                              input logic full);
    logic [31:0] w;
    w = '0;
    w[STAT_OVF_BIT]  = ovf;
    w[STAT_BUSY_BIT] = busy;
    w[STAT_FULL_BIT] = full;
    return w;
  endfunction

endpackage

// File: rtl/mmio_uart_tx_byte_fifo.sv
// byte_fifo -- byte queue feeding the UART shifter.
// DEPTH==1 collapses to a single holding register; larger depths use a ring
// buffer with pointers wrapping modulo DEPTH. A push while full is accepted
// only when a pop happens on the same edge.
module byte_fifo #(
  parameter int DEPTH = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       i_push,
  input  logic       i_pop,
  input  logic [7:0] i_data,
  output logic [7:0] o_data,
  output logic       o_full,
  output logic       o_empty
);

  generate
    if (DEPTH == 1) begin : g_hold
      logic       r_valid;
      logic [7:0] r_data;

      // Holding register: a refill may land on the same edge as the pop
      always_ff @(posedge clk) begin
        if (reset) begin
          r_valid <= 1'b0;
          r_data  <= '0;
        end else if (i_push && (!r_valid || i_pop)) begin
          r_valid <= 1'b1;
          r_data  <= i_data;
        end else if (i_pop) begin
          r_valid <= 1'b0;
        end
      end

      assign o_data  = r_data;
      assign o_full  = r_valid;
      assign o_empty = ~r_valid;
    end else begin : g_ring
      localparam int PTR_W = $clog2(DEPTH);
      localparam int CNT_W = PTR_W + 1;

      logic [7:0]       r_mem [DEPTH];
      logic [PTR_W-1:0] r_wr_ptr;
      logic [PTR_W-1:0] r_rd_ptr;
      logic [CNT_W-1:0] r_count;
      logic             w_do_push;
      logic             w_do_pop;

      function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
      endfunction

      assign o_full    = (r_count == CNT_W'(DEPTH));
      assign o_empty   = (r_count == '0);
      assign w_do_pop  = i_pop & ~o_empty;
      assign w_do_push = i_push & (~o_full | w_do_pop);
      assign o_data    = r_mem[r_rd_ptr];

      // Storage array, written only on an accepted push
      always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr] <= i_data;
      end

      // Pointers and occupancy count
      always_ff @(posedge clk) begin
        if (reset) begin
          r_wr_ptr <= '0;
          r_rd_ptr <= '0;
          r_count  <= '0;
        end else begin
          if (w_do_push) r_wr_ptr <= ptr_inc(r_wr_ptr);
          if (w_do_pop)  r_rd_ptr <= ptr_inc(r_rd_ptr);
          case ({w_do_push, w_do_pop})
            2'b10:   r_count <= r_count + CNT_W'(1);
            2'b01:   r_count <= r_count - CNT_W'(1);
            default: r_count <= r_count;
          endcase
        end
      end
    end
  endgenerate

endmodule

// File: rtl/mmio_uart_tx.sv
// mmio_uart_tx -- memory-mapped 8N1 UART transmitter.
// TXDATA at BASE_ADDR pushes a byte; STATUS at BASE_ADDR+4 reads
// {overflow, busy, full} and clears overflow on a write with bit 2 set.
// Build macro MMIO_UART_TX_FIFO_EN gives an 8-entry FIFO, else a holding register.
module mmio_uart_tx
  import mmio_uart_tx_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0000_2000,
  parameter int          BAUD_DIV  = 104
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] addr,
  input  logic [31:0] write_data,
  input  logic        memwrite,
  input  logic        memread,
  output logic [31:0] read_data,
  output logic        tx_o,
  output logic        busy_o
);

  tx_state_e   r_state;
  tx_state_e   w_state_nxt;
  logic [15:0] r_baud_cnt;
  logic [2:0]  r_bit_idx;
  logic [7:0]  r_shift;
  logic        r_tx;
  logic        r_ovf;

  logic        w_sel_tx;
  logic        w_sel_stat;
  logic        w_push;
  logic        w_pop;
  logic        w_drop;
  logic        w_ovf_clr;
  logic        w_cnt_done;
  logic        w_fifo_full;
  logic        w_fifo_empty;
  logic [7:0]  w_fifo_data;
  logic        w_unused_wdata;

  // Only the low byte of a TXDATA write carries payload
  assign w_unused_wdata = ^write_data[31:8];

  assign w_sel_tx   = (addr == BASE_ADDR + TXDATA_OFS);
  assign w_sel_stat = (addr == BASE_ADDR + STATUS_OFS);
  assign w_push     = memwrite & w_sel_tx & ~reset;
  assign w_drop     = w_push & w_fifo_full & ~w_pop;
  assign w_ovf_clr  = memwrite & w_sel_stat & write_data[STAT_OVF_BIT] & ~reset;
  assign w_cnt_done = (r_baud_cnt == 16'(BAUD_DIV - 1));

  byte_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_data  (write_data[7:0]),
    .o_data  (w_fifo_data),
    .o_full  (w_fifo_full),
    .o_empty (w_fifo_empty)
  );

  // Next-state and pop decision; STOP chains straight into START when data waits
  always_comb begin
    w_state_nxt = r_state;
    w_pop       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (!w_fifo_empty) begin
          w_pop       = 1'b1;
          w_state_nxt = ST_START;
        end
      end
      ST_START: begin
        if (w_cnt_done) w_state_nxt = ST_DATA;
      end
      ST_DATA: begin
        if (w_cnt_done && (r_bit_idx == 3'd7)) w_state_nxt = ST_STOP;
      end
      ST_STOP: begin
        if (w_cnt_done) begin
          if (!w_fifo_empty) begin
            w_pop       = 1'b1;
            w_state_nxt = ST_START;
          end else begin
            w_state_nxt = ST_IDLE;
          end
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Baud timer, bit index, shifter load and registered serial line
  always_ff @(posedge clk) begin
    if (reset) begin
      r_baud_cnt <= '0;
      r_bit_idx  <= '0;
      r_shift    <= '0;
      r_tx       <= 1'b1;
    end else begin
      if (r_state == ST_IDLE || w_cnt_done) r_baud_cnt <= '0;
      else                                  r_baud_cnt <= r_baud_cnt + 16'd1;

      if (r_state == ST_DATA && w_cnt_done) r_bit_idx <= r_bit_idx + 3'd1;

      if (w_pop) r_shift <= w_fifo_data;

      // Line follows the state one cycle later, so every bit lasts BAUD_DIV cycles
      case (r_state)
        ST_START: r_tx <= 1'b0;
        ST_DATA:  r_tx <= r_shift[r_bit_idx];
        default:  r_tx <= 1'b1;
      endcase
    end
  end

  // Sticky overflow; a dropped push beats a same-cycle clear
  always_ff @(posedge clk) begin
    if (reset)          r_ovf <= 1'b0;
    else if (w_drop)    r_ovf <= 1'b1;
    else if (w_ovf_clr) r_ovf <= 1'b0;
  end

  assign tx_o      = r_tx;
  assign busy_o    = (r_state != ST_IDLE) | ~w_fifo_empty;
  assign read_data = (memread && w_sel_stat) ? status_word(r_ovf, busy_o, w_fifo_full)
                                             : 32'h0;

endmodule
